// File: rtl/alu_logic_arbiter_if.sv
// Bus between the requesters, the arbiter and the shared logic unit.
// The arbiter connects through the slave modport; clients and the logic unit use master.
interface alu_logic_arbiter_if #(
    parameter int W   = 16,
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]     REQ;
    logic [2*N-1:0]   OP;
    logic [W*N-1:0]   A_IN;
    logic [W*N-1:0]   B_IN;
    logic [W-1:0]     LU_A;
    logic [W-1:0]     LU_B;
    logic [1:0]       LU_OP;
    logic [W-1:0]     LU_RES;
    logic [N-1:0]     ACK;
    logic [W-1:0]     RESULT;
    logic [IDW-1:0]   RES_ID;
    logic             BUSY;

    modport master (
        output REQ, OP, A_IN, B_IN, LU_RES,
        input  LU_A, LU_B, LU_OP, ACK, RESULT, RES_ID, BUSY
    );

    modport slave (
        input  REQ, OP, A_IN, B_IN, LU_RES,
        output LU_A, LU_B, LU_OP, ACK, RESULT, RES_ID, BUSY
    );
endinterface

// File: rtl/alu_logic_arbiter.sv
// Round-robin arbiter that shares one combinational bitwise logic unit between N requesters.
// Each operation runs IDLE (grant) -> EXEC (unit settles) -> DONE (one-cycle ACK).
module alu_logic_arbiter #(
    parameter int W   = 16,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input logic               CLK,
    input logic               RST_N,
    alu_logic_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [W-1:0]   lu_a_q, lu_a_d;
    logic [W-1:0]   lu_b_q, lu_b_d;
    logic [1:0]     lu_op_q, lu_op_d;
    logic [W-1:0]   result_q, result_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [N-1:0]   ack_q, ack_d;
    logic           busy_q, busy_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   sel_a, sel_b;
    logic [1:0]     sel_op;

    // Search from the pointer upward first, then wrap to the low indices below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < N; j++) begin
            if (!grant_found && bus.REQ[j] && (IDW'(j) >= ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!grant_found && bus.REQ[j] && (IDW'(j) < ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int j = 0; j < N; j++) begin
            if (IDW'(j) == grant_idx) begin
                sel_a  = bus.A_IN[W*j +: W];
                sel_b  = bus.B_IN[W*j +: W];
                sel_op = bus.OP[2*j +: 2];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        lu_a_d   = lu_a_q;
        lu_b_d   = lu_b_q;
        lu_op_d  = lu_op_q;
        result_d = result_q;
        res_id_d = res_id_q;
        ack_d    = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    lu_a_d  = sel_a;
                    lu_b_d  = sel_b;
                    lu_op_d = sel_op;
                    gid_d   = grant_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = bus.LU_RES;
                res_id_d = gid_q;
                for (int j = 0; j < N; j++) begin
                    ack_d[j] = (IDW'(j) == gid_q);
                end
                ptr_d   = (gid_q == IDW'(N-1)) ? '0 : gid_q + 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == EXEC) || (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gid_q    <= '0;
            lu_a_q   <= '0;
            lu_b_q   <= '0;
            lu_op_q  <= '0;
            result_q <= '0;
            res_id_q <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            lu_a_q   <= lu_a_d;
            lu_b_q   <= lu_b_d;
            lu_op_q  <= lu_op_d;
            result_q <= result_d;
            res_id_q <= res_id_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.LU_A   = lu_a_q;
    assign bus.LU_B   = lu_b_q;
    assign bus.LU_OP  = lu_op_q;
    assign bus.RESULT = result_q;
    assign bus.RES_ID = res_id_q;
    assign bus.ACK    = ack_q;
    assign bus.BUSY   = busy_q;

endmodule
